// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-detects request lines, waits for a safe instruction boundary,
// injects a two-word interrupt sequence, and redirects fetch to the serviced vector.
module interrupt_controller #(
    parameter int unsigned NUM_IRQ        = 4,
    parameter int unsigned VEC_W          = 2,
    parameter int unsigned BRANCH_STALLS  = 2,
    parameter logic [15:0] NOP_WORD       = 16'h07F8,
    parameter logic [15:0] INT_WORD1      = 16'hF480,
    parameter logic [15:0] INT_WORD2_BASE = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [4:0]         op_code,
    input  logic [2:0]         function_bits,
    input  logic               iam_jmp,
    output logic               int_stall,
    output logic               int_inject,
    output logic [15:0]        int_instruction,
    output logic               int_bubble,
    output logic               int_to_fetch,
    output logic [VEC_W-1:0]   int_vector,
    output logic [NUM_IRQ-1:0] int_pending,
    output logic               int_busy
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StClassify = 3'd1;
    localparam logic [2:0] StPass     = 3'd2;
    localparam logic [2:0] StDrain    = 3'd3;
    localparam logic [2:0] StPush1    = 3'd4;
    localparam logic [2:0] StPush2    = 3'd5;
    localparam logic [2:0] StRedirect = 3'd6;

    logic [2:0]         state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] rise, ready, clr;
    logic [VEC_W-1:0]   sel;
    logic               is_branch, is_two_word;

    assign rise  = irq_req & ~irq_q;
    assign ready = pending_q & ~irq_mask;

    // Scan high to low so the lowest-index ready channel wins.
    always_comb begin
        sel = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (ready[i]) sel = VEC_W'(i);
        end
    end

    // A fresh edge in the redirect cycle beats the clear of the serviced bit.
    always_comb begin
        clr = '0;
        if (state_q == StRedirect) clr[vec_q] = 1'b1;
        pending_d = (pending_q & ~clr) | rise;
    end

    always_comb begin
        is_branch   = op_code inside {5'b11001, 5'b11011, 5'b10111, 5'b10110, 5'b10101, 5'b10100};
        is_two_word = (function_bits == 3'b100) || (op_code inside {5'b11000, 5'b11010});
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        case (state_q)
            StIdle: begin
                if (|ready) begin
                    state_d = StClassify;
                    vec_d   = sel;
                end
            end
            StClassify: begin
                if (is_branch) begin
                    state_d = StDrain;
                    cnt_d   = 3'(BRANCH_STALLS);
                end else if (is_two_word) begin
                    state_d = StPass;
                end else if (iam_jmp) begin
                    state_d = StDrain;
                    cnt_d   = 3'd1;
                end else begin
                    state_d = StPush1;
                end
            end
            StPass:     state_d = StClassify;
            StDrain: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = StPush1;
            end
            StPush1:    state_d = StPush2;
            StPush2:    state_d = StRedirect;
            StRedirect: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            vec_q     <= '0;
            irq_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vec_q     <= vec_d;
            irq_q     <= irq_req;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        int_stall       = 1'b0;
        int_inject      = 1'b0;
        int_instruction = '0;
        int_bubble      = 1'b0;
        int_to_fetch    = 1'b0;
        int_vector      = '0;
        case (state_q)
            StDrain: begin
                int_stall       = 1'b1;
                int_inject      = 1'b1;
                int_bubble      = 1'b1;
                int_instruction = NOP_WORD;
            end
            StPush1: begin
                int_stall       = 1'b1;
                int_inject      = 1'b1;
                int_instruction = INT_WORD1;
            end
            StPush2: begin
                int_stall       = 1'b1;
                int_inject      = 1'b1;
                int_instruction = {INT_WORD2_BASE[15:VEC_W], vec_q};
            end
            StRedirect: begin
                int_to_fetch = 1'b1;
                int_vector   = vec_q;
            end
            default: ;
        endcase
    end

    assign int_pending = pending_q;
    assign int_busy    = (state_q != StIdle);

endmodule
